ghost_move_ctrl: RTL
====================

Name: ghost_move_ctrl

Overview:
- Downstream consumer of the ghost random-direction generator. Takes its 4-bit one-hot direction and moves one ghost sprite by a fixed step once per frame.
- Handles wall collisions: undoes the last step, stops, and pulses a request back to the generator for a new direction.
- Outputs feed the ghost object's draw logic (top-left X/Y) and the collision/game-state logic.

Parameters:
- INIT_X, 320, reset/respawn top-left X (pixels)
- INIT_Y, 240, reset/respawn top-left Y (pixels)
- SPEED, 2, pixels moved per frame (1..15)
- X_MIN, 0, minimum legal top-left X
- X_MAX, 608, maximum legal top-left X
- Y_MIN, 0, minimum legal top-left Y
- Y_MAX, 448, maximum legal top-left Y
- TURN_FRAMES, 32, frames of free movement before a voluntary new-direction request (>=2)
- REQ_TIMEOUT, 16, frames to wait for a valid direction before re-requesting

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per VGA frame
- enable  in  1  1 = game running; 0 = freeze all state
- respawn  in  1  one-cycle pulse: return to INIT position and stop
- collision  in  1  ghost-vs-wall hit, may be asserted any cycle within a frame
- dirIn  in  4  one-hot from the generator: 0001 down, 0010 right, 0100 up, 1000 left; 0000 means none
- dirReq  out  1  new-direction request, drives the generator's rise input
- curDir  out  4  current movement direction, one-hot or 0000
- topLeftX  out  11  signed ghost top-left X
- topLeftY  out  11  signed ghost top-left Y
- moving  out  1  high in MOVE state

Behaviour:
- Reset (synchronous, clk edge with reset=1): topLeftX=INIT_X, topLeftY=INIT_Y, curDir=0000, dirReq=0, moving=0, hitFlag=0, all counters=0, state=REQ.
- Valid dirIn: exactly one bit set. Zero or multi-hot values are ignored.
- FSM states: REQ, WAIT, MOVE, BACKOFF.
- REQ: dirReq=1 for exactly 2 clk cycles, then go to WAIT. The generator is edge-sensitive, so dirReq must fall between requests.
- WAIT: on the first clk with valid dirIn, latch curDir<=dirIn, clear frame counters, go to MOVE. dirIn must differ from the direction held when the request was issued; if it is equal, keep waiting. On the REQ_TIMEOUT-th startOfFrame with no accepted direction, return to REQ.
- MOVE: moving=1. On each startOfFrame, if hitFlag=0, add or subtract SPEED on the axis selected by curDir:
  - down: Y+
  - up: Y-
  - right: X+
  - left: X-
- Clamp: if the new coordinate is outside [MIN,MAX], clamp it to the bound and treat it as a collision at the next startOfFrame.
- Voluntary turn: after TURN_FRAMES moved frames, go to REQ keeping curDir. Position keeps updating with the old curDir until a new direction is accepted.
- collision: any cycle with collision=1 sets hitFlag (sticky until consumed).
- At startOfFrame in MOVE with hitFlag=1:
  - step SPEED opposite curDir (undo the last move), no forward move
  - clear hitFlag, set curDir=0000, go to BACKOFF
- BACKOFF: wait exactly one startOfFrame, then go to REQ. This lets the collision logic settle off the wall.
- collision and startOfFrame in the same cycle: hitFlag is considered set for that frame, so the undo is taken, not a forward move.
- collision outside MOVE: ignored (hitFlag not set).
- respawn (priority over everything except reset): position=INIT, curDir=0000, hitFlag=0, counters=0, state=REQ.
- enable=0: no state, position or counter change, and dirReq forced to 0. An in-progress REQ pulse restarts from REQ when enable returns.
- Arithmetic: 11-bit signed. SPEED is zero-extended. Overflow cannot occur within the bounds.
- Latency: direction accepted 1 clk after dirIn becomes valid. Position changes on the clk following the startOfFrame pulse.

Test Plan:
- Reset → REQ, dirReq high 2 clk → dirIn=0010 → MOVE, curDir=0010. Then 3 startOfFrame pulses → topLeftX=326, topLeftY=240.
- In MOVE right at X=326, pulse collision mid-frame → next startOfFrame: X=324, curDir=0000, BACKOFF. One more frame → REQ, dirReq 2-clk pulse.
- Moving left from X=2 with SPEED=2 → X=0, then at the next frame clamped and blocked → X=2, curDir=0000, BACKOFF.
- WAIT with dirIn=0000 or 0110 for 16 frames → no move; a second dirReq pulse is issued at the REQ_TIMEOUT-th frame.
- TURN_FRAMES=32 elapsed in MOVE → dirReq pulses while X keeps advancing. dirIn=0100 → curDir=0100 and Y decreases by 2 per frame.
- enable=0 for 5 frames → position and curDir unchanged, dirReq=0. Then respawn → X=320, Y=240, curDir=0000, state REQ.

Source files
------------

// File: rtl/ghost_move_ctrl_if.sv
// ============================================================================
// Module : ghost_move_ctrl_if
// Brief  : Frame/direction/position bundle between game logic and the ghost
//          movement controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ghost_move_ctrl_if;
    logic               startOfFrame;
    logic               enable;
    logic               respawn;
    logic               collision;
    logic [3:0]         dirIn;
    logic               dirReq;
    logic [3:0]         curDir;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               moving;

    modport master (
        output startOfFrame, enable, respawn, collision, dirIn,
        input  dirReq, curDir, topLeftX, topLeftY, moving
    );

    modport slave (
        input  startOfFrame, enable, respawn, collision, dirIn,
        output dirReq, curDir, topLeftX, topLeftY, moving
    );
endinterface

`default_nettype wire

// File: rtl/ghost_move_ctrl.sv
// ============================================================================
// Module : ghost_move_ctrl
// Brief  : Moves one ghost sprite per frame along a one-hot direction, backs
//          off walls and requests new directions from the random generator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ghost_move_ctrl #(
    parameter int INIT_X      = 320,
    parameter int INIT_Y      = 240,
    parameter int SPEED       = 2,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 608,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 448,
    parameter int TURN_FRAMES = 32,
    parameter int REQ_TIMEOUT = 16
) (
    input  wire                 clk,
    input  wire                 reset,
    ghost_move_ctrl_if.slave    bus
);

    localparam int CNT_MAX = (TURN_FRAMES > REQ_TIMEOUT) ? TURN_FRAMES : REQ_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic signed [10:0] c_STEP  = 11'(SPEED);
    localparam logic signed [10:0] c_ZERO  = 11'sd0;
    localparam logic signed [10:0] c_X_MIN = 11'(X_MIN);
    localparam logic signed [10:0] c_X_MAX = 11'(X_MAX);
    localparam logic signed [10:0] c_Y_MIN = 11'(Y_MIN);
    localparam logic signed [10:0] c_Y_MAX = 11'(Y_MAX);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_MOVE    = 2'd2,
        S_BACKOFF = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic signed [10:0] x_q, x_d, y_q, y_d;
    logic [3:0]         dir_q, dir_d;
    logic               hit_q, hit_d;
    logic               req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]   frm_cnt_q, frm_cnt_d;

    logic signed [10:0] w_dx, w_dy;
    logic signed [10:0] w_fwd_x_raw, w_fwd_y_raw, w_fwd_x, w_fwd_y;
    logic signed [10:0] w_bk_x, w_bk_y;
    logic               w_fwd_clamped;
    logic               w_dir_ok;

    function automatic logic signed [10:0] f_clamp(
        input logic signed [10:0] v,
        input logic signed [10:0] lo,
        input logic signed [10:0] hi
    );
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    // Signed per-axis step for the current direction; zero when stopped.
    assign w_dx = dir_q[1] ? c_STEP : (dir_q[3] ? -c_STEP : c_ZERO);
    assign w_dy = dir_q[0] ? c_STEP : (dir_q[2] ? -c_STEP : c_ZERO);

    assign w_fwd_x_raw   = x_q + w_dx;
    assign w_fwd_y_raw   = y_q + w_dy;
    assign w_fwd_x       = f_clamp(w_fwd_x_raw, c_X_MIN, c_X_MAX);
    assign w_fwd_y       = f_clamp(w_fwd_y_raw, c_Y_MIN, c_Y_MAX);
    assign w_fwd_clamped = (w_fwd_x != w_fwd_x_raw) || (w_fwd_y != w_fwd_y_raw);
    assign w_bk_x        = f_clamp(x_q - w_dx, c_X_MIN, c_X_MAX);
    assign w_bk_y        = f_clamp(y_q - w_dy, c_Y_MIN, c_Y_MAX);

    // A new direction must be one-hot and differ from the one being replaced.
    assign w_dir_ok = (bus.dirIn != 4'b0000)
                   && ((bus.dirIn & (bus.dirIn - 4'd1)) == 4'b0000)
                   && (bus.dirIn != dir_q);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        hit_d     = hit_q;
        req_cnt_d = req_cnt_q;
        frm_cnt_d = frm_cnt_q;

        if (bus.respawn) begin
            state_d   = S_REQ;
            x_d       = 11'(INIT_X);
            y_d       = 11'(INIT_Y);
            dir_d     = 4'b0000;
            hit_d     = 1'b0;
            req_cnt_d = 1'b0;
            frm_cnt_d = '0;
        end else if (!bus.enable) begin
            req_cnt_d = 1'b0;
        end else begin
            // Keep gliding on the old heading while a replacement is fetched.
            if ((state_q == S_REQ || state_q == S_WAIT) && bus.startOfFrame) begin
                x_d = w_fwd_x;
                y_d = w_fwd_y;
            end
            unique case (state_q)
                S_REQ: begin
                    req_cnt_d = 1'b1;
                    if (req_cnt_q) begin
                        req_cnt_d = 1'b0;
                        state_d   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_dir_ok) begin
                        dir_d     = bus.dirIn;
                        frm_cnt_d = '0;
                        state_d   = S_MOVE;
                    end else if (bus.startOfFrame) begin
                        frm_cnt_d = frm_cnt_q + CNT_W'(1);
                        if (frm_cnt_q == CNT_W'(REQ_TIMEOUT - 1)) begin
                            frm_cnt_d = '0;
                            state_d   = S_REQ;
                        end
                    end
                end
                S_MOVE: begin
                    if (bus.collision) hit_d = 1'b1;
                    if (bus.startOfFrame) begin
                        if (hit_q || bus.collision) begin
                            x_d       = w_bk_x;
                            y_d       = w_bk_y;
                            hit_d     = 1'b0;
                            dir_d     = 4'b0000;
                            frm_cnt_d = '0;
                            state_d   = S_BACKOFF;
                        end else begin
                            x_d       = w_fwd_x;
                            y_d       = w_fwd_y;
                            frm_cnt_d = frm_cnt_q + CNT_W'(1);
                            // A clamped step is a wall hit; it is resolved next frame.
                            if (w_fwd_clamped) begin
                                hit_d = 1'b1;
                            end else if (frm_cnt_q == CNT_W'(TURN_FRAMES - 1)) begin
                                frm_cnt_d = '0;
                                state_d   = S_REQ;
                            end
                        end
                    end
                end
                S_BACKOFF: begin
                    if (bus.startOfFrame) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_REQ;
            x_q       <= 11'(INIT_X);
            y_q       <= 11'(INIT_Y);
            dir_q     <= 4'b0000;
            hit_q     <= 1'b0;
            req_cnt_q <= 1'b0;
            frm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
            hit_q     <= hit_d;
            req_cnt_q <= req_cnt_d;
            frm_cnt_q <= frm_cnt_d;
        end
    end

    assign bus.dirReq   = (state_q == S_REQ) && bus.enable && !reset;
    assign bus.curDir   = dir_q;
    assign bus.topLeftX = x_q;
    assign bus.topLeftY = y_q;
    assign bus.moving   = (state_q == S_MOVE);

endmodule

`default_nettype wire
